// File: rtl/psum_accum_array_pkg.sv
// Shared definitions for the partial-sum accumulator array.
//   ACC_MODE_OVR / ACC_MODE_ACC : in_mode encodings (1x = no-op)
//   DEF_NUM_COL / DEF_ACC_W     : default column count and accumulator width
//   drain_state_e               : drain engine states
package psum_accum_array_pkg;

  localparam logic [1:0] ACC_MODE_OVR = 2'b00;
  localparam logic [1:0] ACC_MODE_ACC = 2'b01;

  localparam int unsigned DEF_NUM_COL = 16;
  localparam int unsigned DEF_ACC_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND
  } drain_state_e;

endpackage

// File: rtl/psum_accum_array_lane_alu.sv
// acc_lane_alu: per-lane update datapath for one accumulator entry.
//   mode : 00 overwrite, 01 accumulate, 1x hold
//   cur  : current stored value (signed, ACC_W)
//   psum : incoming partial sum (signed, PSUM_W)
//   nxt  : value to store
//   sat  : accumulate overflowed and was clamped (only when SATURATE=1)
module acc_lane_alu
  import psum_accum_array_pkg::*;
#(
  parameter int unsigned PSUM_W   = 32,
  parameter int unsigned ACC_W    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [1:0]        mode,
  input  logic [ACC_W-1:0]  cur,
  input  logic [PSUM_W-1:0] psum,
  output logic [ACC_W-1:0]  nxt,
  output logic              sat
);

  localparam int unsigned EW = ACC_W + 1;

  logic signed [ACC_W:0] psum_ext;
  logic signed [ACC_W:0] cur_ext;
  logic signed [ACC_W:0] sum;
  logic                  ovf;

  always_comb begin
    psum_ext = EW'(signed'(psum));
    cur_ext  = EW'(signed'(cur));
    sum      = cur_ext + psum_ext;
    // One guard bit: overflow iff the guard and the ACC_W sign bit disagree.
    ovf      = sum[ACC_W] ^ sum[ACC_W-1];
    nxt      = cur;
    sat      = 1'b0;
    case (mode)
      ACC_MODE_OVR: nxt = psum_ext[ACC_W-1:0];
      ACC_MODE_ACC: begin
        nxt = sum[ACC_W-1:0];
        if (SATURATE && ovf) begin
          // Guard bit gives the true sign: negative -> min, positive -> max.
          nxt = {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}};
          sat = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/psum_accum_array.sv
// psum_accum_array: DEPTH x NUM_COL partial-sum accumulator with drain engine.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : write beat handshake (ready only while idle)
//   in_addr, in_mode      : target row, 00 overwrite / 01 accumulate / 1x no-op
//   in_psum_vec           : packed psums, lane c at [c*PSUM_W +: PSUM_W]
//   drain_start           : pulse to stream rows 0..DEPTH-1 out
//   drain_busy            : drain engine active
//   out_valid/out_ready   : drain beat handshake
//   out_addr, out_last    : row of current beat, last-row marker
//   out_acc_vec           : row contents, lane c at [c*ACC_W +: ACC_W]
//   sat_flag              : sticky saturation flag, cleared by drain_start
module psum_accum_array
  import psum_accum_array_pkg::*;
#(
  parameter int unsigned NUM_COL      = DEF_NUM_COL,
  parameter int unsigned PSUM_W       = 32,
  parameter int unsigned ACC_W        = DEF_ACC_W,
  parameter int unsigned DEPTH        = 16,
  parameter bit          SATURATE     = 1'b1,
  parameter bit          CLR_ON_DRAIN = 1'b1,
  localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [1:0]                in_mode,
  input  logic [NUM_COL*PSUM_W-1:0] in_psum_vec,
  input  logic                      drain_start,
  output logic                      drain_busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_W-1:0]         out_addr,
  output logic                      out_last,
  output logic [NUM_COL*ACC_W-1:0]  out_acc_vec,
  output logic                      sat_flag
);

  localparam int unsigned        ROW_W     = NUM_COL * ACC_W;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);

  drain_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ROW_W-1:0]   mem [DEPTH];
  logic [ROW_W-1:0]   cur_row;
  logic [ROW_W-1:0]   nxt_row;
  logic [NUM_COL-1:0] lane_sat;
  logic [ROW_W-1:0]   acc_q;
  logic               sat_q;
  logic               wr_en;
  logic               load_en;
  logic               clr_en;
  logic               start_drain;

  assign cur_row = mem[in_addr];
  assign wr_en   = in_valid && (state_q == ST_IDLE) && (32'(in_addr) < DEPTH);

  for (genvar c = 0; c < NUM_COL; c++) begin : g_lane
    acc_lane_alu #(
      .PSUM_W  (PSUM_W),
      .ACC_W   (ACC_W),
      .SATURATE(SATURATE)
    ) u_alu (
      .mode(in_mode),
      .cur (cur_row[c*ACC_W +: ACC_W]),
      .psum(in_psum_vec[c*PSUM_W +: PSUM_W]),
      .nxt (nxt_row[c*ACC_W +: ACC_W]),
      .sat (lane_sat[c])
    );
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    load_en     = 1'b0;
    clr_en      = 1'b0;
    start_drain = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (drain_start) begin
          state_d     = ST_LOAD;
          rd_ptr_d    = '0;
          start_drain = 1'b1;
        end
      end
      ST_LOAD: begin
        load_en = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          clr_en = CLR_ON_DRAIN;
          if (rd_ptr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            state_d  = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      if (load_en) acc_q <= mem[rd_ptr_q];
      // A write sharing the drain_start edge commits, but the flag restarts clean.
      if (start_drain)              sat_q <= 1'b0;
      else if (wr_en && |lane_sat)  sat_q <= 1'b1;
    end
  end

  // Writes only happen in IDLE and clears only in SEND, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else if (wr_en) begin
      mem[in_addr] <= nxt_row;
    end else if (clr_en) begin
      mem[rd_ptr_q] <= '0;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign drain_busy  = (state_q != ST_IDLE);
  assign out_valid   = (state_q == ST_SEND);
  assign out_addr    = rd_ptr_q;
  assign out_last    = (state_q == ST_SEND) && (rd_ptr_q == LAST_ADDR);
  assign out_acc_vec = acc_q;
  assign sat_flag    = sat_q;

endmodule
